barrel_shifter_pipe: RTL



---
 rtl/barrel_shifter_pipe.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe
//   Pipelined shifter/rotator for the ALU datapath. It resolves one
//   shift-amount bit per register stage, so there are SHAMT_W stages and a
//   beat leaves SHAMT_W cycles after it is accepted. Throughput is one beat
//   per cycle. The whole pipe stalls when the output is held.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; discards every beat in flight
//   in_valid   input beat valid
//   in_ready   pipe can take a beat this cycle (out_ready | ~out_valid)
//   in_data    operand, WIDTH bits
//   in_shamt   shift amount, SHAMT_W bits
//   in_mode    000 SRA, 001 SRL, 010 SLA, 011 SLL, 100 ROR, 101 ROL, 11x pass
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   result, WIDTH bits
//   out_carry  last bit shifted out (0 for rotates, pass-through, shamt=0)
//   out_zero   out_data == 0; meaningful only while out_valid is high
//
// WIDTH must equal 2**SHAMT_W.

module barrel_shifter_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [2:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_carry,
    output logic               out_zero
);

    localparam int STAGES = SHAMT_W;

    // One conditional shift by 2**k. Returns {carry, data}. The carry is
    // reloaded only by shifting stages that are enabled, so after the last
    // stage it holds the final bit shifted out. Arithmetic right shifts
    // keep the operand MSB at every stage, so each stage can fill from the
    // current MSB and still reproduce the original sign.
    function automatic logic [WIDTH:0] shift_step(
        input logic signed [WIDTH-1:0] d,
        input logic                    en,
        input logic [2:0]              mode,
        input logic                    c,
        input int                      k
    );
        int                      amt;
        logic [SHAMT_W-1:0]      lo_idx;
        logic [SHAMT_W-1:0]      hi_idx;
        logic signed [WIDTH-1:0] r;
        logic                    co;
        amt    = 1 << k;
        lo_idx = SHAMT_W'(amt - 1);
        hi_idx = SHAMT_W'(WIDTH - amt);
        r      = d;
        co     = c;
        if (en) begin
            case (mode)
                3'b000: begin
                    r  = d >>> amt;
                    co = d[lo_idx];
                end
                3'b001: begin
                    r  = d >> amt;
                    co = d[lo_idx];
                end
                3'b010, 3'b011: begin
                    r  = d << amt;
                    co = d[hi_idx];
                end
                3'b100: r = (d >> amt) | (d << (WIDTH - amt));
                3'b101: r = (d << amt) | (d >> (WIDTH - amt));
                default: r = d;
            endcase
        end
        return {co, r};
    endfunction

    logic signed [WIDTH-1:0] data_p  [STAGES];
    logic [SHAMT_W-1:0]      shamt_p [STAGES];
    logic [2:0]              mode_p  [STAGES];
    logic [STAGES-1:0]       carry_p;
    logic [STAGES-1:0]       vld_p;

    logic signed [WIDTH-1:0] src_data  [STAGES];
    logic [SHAMT_W-1:0]      src_shamt [STAGES];
    logic [2:0]              src_mode  [STAGES];
    logic [STAGES-1:0]       src_carry;
    logic signed [WIDTH-1:0] nxt_data  [STAGES];
    logic [STAGES-1:0]       nxt_carry;
    logic                    advance;

    // Global stall: everything moves together or nothing moves.
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    // Stage k input is stage k-1 output; stage 0 takes the input port and
    // starts with a clear carry.
    assign src_carry = {carry_p[STAGES-2:0], 1'b0};

    always_comb begin
        src_data[0]  = in_data;
        src_shamt[0] = in_shamt;
        src_mode[0]  = in_mode;
        for (int k = 1; k < STAGES; k++) begin
            src_data[k]  = data_p[k-1];
            src_shamt[k] = shamt_p[k-1];
            src_mode[k]  = mode_p[k-1];
        end
        nxt_carry = '0;
        for (int k = 0; k < STAGES; k++) begin
            {nxt_carry[k], nxt_data[k]} = shift_step(
                src_data[k],
                |(src_shamt[k] & (SHAMT_W'(1) << k)),
                src_mode[k],
                src_carry[k],
                k);
        end
    end

    // Stage registers 0..STAGES-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p   <= '0;
            carry_p <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_p[k]  <= '0;
                shamt_p[k] <= '0;
                mode_p[k]  <= '0;
            end
        end else if (advance) begin
            vld_p   <= {vld_p[STAGES-2:0], in_valid};
            carry_p <= nxt_carry;
            for (int k = 0; k < STAGES; k++) begin
                data_p[k]  <= nxt_data[k];
                shamt_p[k] <= src_shamt[k];
                mode_p[k]  <= src_mode[k];
            end
        end
    end

    // Output taps the last stage directly
    assign out_valid = vld_p[STAGES-1];
    assign out_data  = data_p[STAGES-1];
    assign out_carry = carry_p[STAGES-1];
    assign out_zero  = (out_data == '0);

endmodule
